// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb_pkg
// Brief    : Shared widths, requester-index type and round-robin pick helper
//            for the sram_port_arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

   localparam int c_def_addr_w  = 16;
   localparam int c_def_data_w  = 128;
   localparam int c_max_num_req = 8;
   localparam int c_req_idx_w   = $clog2(c_max_num_req);

   typedef logic [c_req_idx_w-1:0]   req_idx_t;
   typedef logic [c_max_num_req-1:0] req_vec_t;

   // First asserted request at or above ptr, wrapping at num_req; one-hot result.
   function automatic req_vec_t rr_pick(input req_vec_t req, input req_idx_t ptr,
                                        input int num_req);
      req_vec_t gnt;
      int       idx;
      logic     found;
      gnt   = '0;
      found = 1'b0;
      for (int k = 0; k < c_max_num_req; k++) begin
         idx = int'(ptr) + k;
         if (idx >= num_req) idx = idx - num_req;
         if ((k < num_req) && !found && req[idx[c_req_idx_w-1:0]]) begin
            gnt[idx[c_req_idx_w-1:0]] = 1'b1;
            found                     = 1'b1;
         end
      end
      return gnt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin arbiter; pointer moves past the winner only when the
//            grant is enabled, so a vetoed candidate keeps its priority.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
   import sram_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic               clock,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               en,
   output logic [NUM_REQ-1:0] pick,
   output logic [NUM_REQ-1:0] gnt
);

   req_vec_t w_req_ext;
   req_vec_t w_pick_ext;
   req_idx_t r_ptr;
   req_idx_t w_win_idx;
   logic     w_unused_pick;

   always_comb begin
      w_req_ext              = '0;
      w_req_ext[NUM_REQ-1:0] = req;
   end

   assign w_pick_ext    = rr_pick(w_req_ext, r_ptr, NUM_REQ);
   assign pick          = w_pick_ext[NUM_REQ-1:0];
   assign w_unused_pick = ^w_pick_ext;
   assign gnt           = en ? pick : '0;

   always_comb begin
      w_win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) w_win_idx = req_idx_t'(i);
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (|gnt) begin
         r_ptr <= (w_win_idx == req_idx_t'(NUM_REQ - 1)) ? '0 : w_win_idx + req_idx_t'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Brief    : Shares one 1R1W SRAM among NUM_REQ requesters with independent
//            round-robin read/write arbitration. ARB_STATS_EN adds counters.
// Revision : 1.0 - initial release
// ============================================================================
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int ADDR_W   = c_def_addr_w,
   parameter int DATA_W   = c_def_data_w,
   parameter int READ_LAT = 1
) (
   input  logic                      clock,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        rdReq,
   input  logic [NUM_REQ*ADDR_W-1:0] rdAddr,
   output logic [NUM_REQ-1:0]        rdGnt,
   output logic [NUM_REQ-1:0]        rdValid,
   output logic [DATA_W-1:0]         rdData,
   input  logic [NUM_REQ-1:0]        wrReq,
   input  logic [NUM_REQ*ADDR_W-1:0] wrAddr,
   input  logic [NUM_REQ*DATA_W-1:0] wrVal,
   output logic [NUM_REQ-1:0]        wrGnt,
   output logic [ADDR_W-1:0]         ReadAddress,
   input  logic [DATA_W-1:0]         ReadBus,
   output logic                      WE,
   output logic [ADDR_W-1:0]         WriteAddress,
   output logic [DATA_W-1:0]         WriteBus,
   output logic                      idle
`ifdef ARB_STATS_EN
   ,
   output logic [31:0]               conflictCount,
   output logic [NUM_REQ*32-1:0]     grantCount
`endif
);

   logic [NUM_REQ-1:0]              w_rd_pick;
   logic [NUM_REQ-1:0]              w_wr_pick;
   logic [ADDR_W-1:0]               w_rd_addr;
   logic [ADDR_W-1:0]               w_wr_addr;
   logic [DATA_W-1:0]               w_wr_data;
   logic                            w_conflict;
   logic [READ_LAT:0][NUM_REQ-1:0]  r_tag_pipe;

   always_comb begin
      w_rd_addr = '0;
      w_wr_addr = '0;
      w_wr_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_rd_pick[i]) w_rd_addr = rdAddr[i*ADDR_W +: ADDR_W];
         if (w_wr_pick[i]) begin
            w_wr_addr = wrAddr[i*ADDR_W +: ADDR_W];
            w_wr_data = wrVal[i*DATA_W +: DATA_W];
         end
      end
   end

   // Write wins a same-address collision; the read retries and sees new data.
   assign w_conflict = (|w_rd_pick) && (|w_wr_pick) && (w_rd_addr == w_wr_addr);

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
      .clock (clock),
      .rst_n (rst_n),
      .req   (rdReq),
      .en    (!w_conflict),
      .pick  (w_rd_pick),
      .gnt   (rdGnt)
   );

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
      .clock (clock),
      .rst_n (rst_n),
      .req   (wrReq),
      .en    (1'b1),
      .pick  (w_wr_pick),
      .gnt   (wrGnt)
   );

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         ReadAddress  <= '0;
         WE           <= 1'b0;
         WriteAddress <= '0;
         WriteBus     <= '0;
      end else begin
         if (|rdGnt) ReadAddress <= w_rd_addr;
         WE <= |wrGnt;
         if (|wrGnt) begin
            WriteAddress <= w_wr_addr;
            WriteBus     <= w_wr_data;
         end
      end
   end

   // Stage 0 mirrors ReadAddress; stage READ_LAT lines up with ReadBus.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_tag_pipe <= '0;
      end else begin
         r_tag_pipe[0] <= rdGnt;
         for (int k = 1; k <= READ_LAT; k++) r_tag_pipe[k] <= r_tag_pipe[k-1];
      end
   end

   assign rdValid = r_tag_pipe[READ_LAT];
   assign rdData  = ReadBus;
   assign idle    = !(|rdReq) && !(|wrReq) && !(|r_tag_pipe) && !WE;

`ifdef ARB_STATS_EN
   logic [31:0] r_conflict_cnt;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_conflict_cnt <= '0;
      end else if (w_conflict && (r_conflict_cnt != '1)) begin
         r_conflict_cnt <= r_conflict_cnt + 32'd1;
      end
   end

   assign conflictCount = r_conflict_cnt;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_grant_cnt
      logic [31:0] r_cnt;
      logic [32:0] w_sum;

      assign w_sum = {1'b0, r_cnt} + 33'(rdGnt[i]) + 33'(wrGnt[i]);

      always_ff @(posedge clock or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= w_sum[32] ? '1 : w_sum[31:0];
         end
      end

      assign grantCount[i*32 +: 32] = r_cnt;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Brief    : Directed bench with a queue-based reference model of sram_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 128;
   localparam int RL = 1;

   logic            clock = 1'b0;
   logic            rst_n = 1'b1;
   logic [N-1:0]    rdReq, wrReq;
   logic [N*AW-1:0] rdAddr, wrAddr;
   logic [N*DW-1:0] wrVal;
   logic [N-1:0]    rdGnt, rdValid, wrGnt;
   logic [DW-1:0]   rdData, WriteBus;
   logic [DW-1:0]   ReadBus = '0;
   logic [AW-1:0]   ReadAddress, WriteAddress;
   logic            WE, idle;
`ifdef ARB_STATS_EN
   logic [31:0]     conflictCount;
   logic [N*32-1:0] grantCount;
`endif

   int vectors     = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   sram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)) dut (
      .clock        (clock),
      .rst_n        (rst_n),
      .rdReq        (rdReq),
      .rdAddr       (rdAddr),
      .rdGnt        (rdGnt),
      .rdValid      (rdValid),
      .rdData       (rdData),
      .wrReq        (wrReq),
      .wrAddr       (wrAddr),
      .wrVal        (wrVal),
      .wrGnt        (wrGnt),
      .ReadAddress  (ReadAddress),
      .ReadBus      (ReadBus),
      .WE           (WE),
      .WriteAddress (WriteAddress),
      .WriteBus     (WriteBus),
      .idle         (idle)
`ifdef ARB_STATS_EN
      ,
      .conflictCount(conflictCount),
      .grantCount   (grantCount)
`endif
   );

   // SRAM: one-cycle registered read, write at the edge that ends the WE cycle
   logic [DW-1:0] sram [256];
   always @(posedge clock) begin
      ReadBus <= sram[ReadAddress[7:0]];
      if (WE) sram[WriteAddress[7:0]] <= WriteBus;
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int            due;
      int            tag;
      logic [DW-1:0] data;
   } rd_evt_t;

   logic [DW-1:0] model_mem [256];
   rd_evt_t       pend[$];
   int            m_rd_ptr, m_wr_ptr, cyc;
   logic [AW-1:0] m_raddr, m_waddr;
   logic [DW-1:0] m_wdata;
   logic          m_we;
   int            m_conf;
   int            m_gcnt [N];

   function automatic int rr_winner(input logic [N-1:0] req, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (req[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int idx);
      logic [N-1:0] v;
      v = '0;
      if (idx >= 0) v[idx] = 1'b1;
      return v;
   endfunction

   always @(negedge clock) begin
      int            rw, ww;
      logic          conflict;
      logic [N-1:0]  exp_rv;
      logic [DW-1:0] exp_rd;
      logic [AW-1:0] a;
      cyc++;
      if (!rst_n) begin
         check("rst_read_address", DW'(ReadAddress), '0);
         check("rst_we", DW'(WE), '0);
         check("rst_write_address", DW'(WriteAddress), '0);
         check("rst_write_bus", WriteBus, '0);
         check("rst_rd_valid", DW'(rdValid), '0);
         check("rst_idle", DW'(idle), DW'(!(|rdReq) && !(|wrReq)));
`ifdef ARB_STATS_EN
         check("rst_conflict_count", DW'(conflictCount), '0);
         check("rst_grant_count", DW'(grantCount), '0);
`endif
         m_rd_ptr = 0; m_wr_ptr = 0; m_raddr = '0; m_waddr = '0; m_wdata = '0; m_we = 1'b0;
         m_conf = 0;
         for (int i = 0; i < N; i++) m_gcnt[i] = 0;
         pend.delete();
      end else begin
         rw = rr_winner(rdReq, m_rd_ptr);
         ww = rr_winner(wrReq, m_wr_ptr);
         conflict = (rw >= 0) && (ww >= 0) && (rdAddr[rw*AW +: AW] == wrAddr[ww*AW +: AW]);
         if (conflict) rw = -1;

         check("m_rd_gnt", DW'(rdGnt), DW'(onehot(rw)));
         check("m_wr_gnt", DW'(wrGnt), DW'(onehot(ww)));
         check("m_read_address", DW'(ReadAddress), DW'(m_raddr));
         check("m_we", DW'(WE), DW'(m_we));
         if (m_we) begin
            check("m_write_address", DW'(WriteAddress), DW'(m_waddr));
            check("m_write_bus", WriteBus, m_wdata);
         end

         exp_rv = '0;
         exp_rd = '0;
         foreach (pend[j]) begin
            if (pend[j].due == cyc) begin
               exp_rv[pend[j].tag] = 1'b1;
               exp_rd              = pend[j].data;
            end
         end
         check("m_rd_valid", DW'(rdValid), DW'(exp_rv));
         if (|exp_rv) check("m_rd_data", rdData, exp_rd);
         check("m_idle", DW'(idle),
               DW'(!(|rdReq) && !(|wrReq) && (pend.size() == 0) && !m_we));
`ifdef ARB_STATS_EN
         check("m_conflict_count", DW'(conflictCount), DW'(m_conf));
         for (int i = 0; i < N; i++)
            check("m_grant_count", DW'(grantCount[i*32 +: 32]), DW'(m_gcnt[i]));
`endif

         while ((pend.size() > 0) && (pend[0].due <= cyc)) void'(pend.pop_front());

         // Read is captured before this cycle's write lands in the memory image
         if (rw >= 0) begin
            a = rdAddr[rw*AW +: AW];
            pend.push_back('{due: cyc + 1 + RL, tag: rw, data: model_mem[a[7:0]]});
            m_raddr  = a;
            m_rd_ptr = (rw + 1) % N;
            m_gcnt[rw]++;
         end
         m_we = (ww >= 0);
         if (ww >= 0) begin
            m_waddr  = wrAddr[ww*AW +: AW];
            m_wdata  = wrVal[ww*DW +: DW];
            model_mem[m_waddr[7:0]] = m_wdata;
            m_wr_ptr = (ww + 1) % N;
            m_gcnt[ww]++;
         end
         if (conflict) m_conf++;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [N-1:0]  exp_g;
      logic [DW-1:0] wv;
      rdReq = '0; wrReq = '0; rdAddr = '0; wrAddr = '0; wrVal = '0;
      for (int i = 0; i < 256; i++) begin
         sram[i]      <= '0;
         model_mem[i]  = '0;
      end
      #0;
      sram[8'h10] <= 128'hAB;  model_mem[8'h10] = 128'hAB;
      sram[8'h20] <= 128'h11;  model_mem[8'h20] = 128'h11;
      for (int i = 0; i < 4; i++) begin
         sram[8'h30 + i]      <= DW'(8'hC0 + i);
         model_mem[8'h30 + i]  = DW'(8'hC0 + i);
      end

      #1 rst_n = 1'b0;
      @(negedge clock);
      check("lit_reset_read_address", DW'(ReadAddress), '0);
      check("lit_reset_we", DW'(WE), '0);
      check("lit_reset_idle", DW'(idle), DW'(1'b1));
      next_cycle();
      rst_n = 1'b1;

      // single read
      rdReq = 4'b0010; rdAddr[1*AW +: AW] = 16'h0010;
      @(negedge clock);
      check("lit_single_rd_gnt", DW'(rdGnt), DW'(4'b0010));
      next_cycle(); rdReq = '0;
      next_cycle();
      @(negedge clock);
      check("lit_single_rd_valid", DW'(rdValid), DW'(4'b0010));
      check("lit_single_rd_data", rdData, 128'hAB);

      // all four from reset release
      next_cycle(); rst_n = 1'b0;
      next_cycle(); rst_n = 1'b1;
      for (int i = 0; i < N; i++) rdAddr[i*AW +: AW] = AW'(16'h0030 + i);
      rdReq = 4'b1111;
      for (int k = 0; k < N; k++) begin
         @(negedge clock);
         exp_g = 4'b0001 << k;
         check("lit_all4_rd_gnt", DW'(rdGnt), DW'(exp_g));
         next_cycle(); rdReq[k] = 1'b0;
      end
      next_cycle();
      @(negedge clock);
      check("lit_all4_last_valid", DW'(rdValid), DW'(4'b1000));
      check("lit_all4_last_data", rdData, 128'hC3);
      next_cycle();
      @(negedge clock);
      check("lit_all4_idle", DW'(idle), DW'(1'b1));

      // fairness: after 2, requester 3 precedes 0
      next_cycle(); rdReq = 4'b0100;
      @(negedge clock);
      check("lit_fair_first", DW'(rdGnt), DW'(4'b0100));
      next_cycle(); rdReq = 4'b1001;
      @(negedge clock);
      check("lit_fair_second", DW'(rdGnt), DW'(4'b1000));
      next_cycle(); rdReq = 4'b0001;
      @(negedge clock);
      check("lit_fair_third", DW'(rdGnt), DW'(4'b0001));
      next_cycle(); rdReq = '0;

      // same-address read/write conflict
      next_cycle();
      rdReq = 4'b0001; rdAddr[0 +: AW] = 16'h0020;
      wrReq = 4'b0010; wrAddr[1*AW +: AW] = 16'h0020; wrVal[1*DW +: DW] = 128'h55;
      @(negedge clock);
      check("lit_conf_wr_gnt", DW'(wrGnt), DW'(4'b0010));
      check("lit_conf_rd_blocked", DW'(rdGnt), '0);
      next_cycle(); wrReq = '0;
      @(negedge clock);
      check("lit_conf_we", DW'(WE), DW'(1'b1));
      check("lit_conf_rd_retry", DW'(rdGnt), DW'(4'b0001));
      next_cycle(); rdReq = '0;
      next_cycle();
      @(negedge clock);
      check("lit_conf_rd_valid", DW'(rdValid), DW'(4'b0001));
      check("lit_conf_rd_data", rdData, 128'h55);
`ifdef ARB_STATS_EN
      check("lit_conf_count", DW'(conflictCount), DW'(32'd1));
`endif

      // concurrent read/write to different addresses, then read back the write
      wv = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      next_cycle();
      rdReq = 4'b0100; rdAddr[2*AW +: AW] = 16'h0001;
      wrReq = 4'b1000; wrAddr[3*AW +: AW] = 16'h0002; wrVal[3*DW +: DW] = wv;
      @(negedge clock);
      check("lit_conc_rd_gnt", DW'(rdGnt), DW'(4'b0100));
      check("lit_conc_wr_gnt", DW'(wrGnt), DW'(4'b1000));
      next_cycle(); rdReq = '0; wrReq = '0;
      @(negedge clock);
      check("lit_conc_write_address", DW'(WriteAddress), DW'(16'h0002));
      check("lit_conc_write_bus", WriteBus, wv);
      next_cycle(); rdReq = 4'b0001; rdAddr[0 +: AW] = 16'h0002;
      next_cycle(); rdReq = '0;
      next_cycle();
      @(negedge clock);
      check("lit_readback_valid", DW'(rdValid), DW'(4'b0001));
      check("lit_readback_data", rdData, wv);

      // reset while a read is in flight
      next_cycle(); rdReq = 4'b0010; rdAddr[1*AW +: AW] = 16'h0010;
      @(negedge clock);
      check("lit_flight_rd_gnt", DW'(rdGnt), DW'(4'b0010));
      next_cycle(); rdReq = '0; rst_n = 1'b0;
      @(negedge clock);
      check("lit_flight_valid", DW'(rdValid), '0);
      check("lit_flight_read_address", DW'(ReadAddress), '0);
      check("lit_flight_we", DW'(WE), '0);
      check("lit_flight_idle", DW'(idle), DW'(1'b1));
      next_cycle(); rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         check("lit_flight_no_valid", DW'(rdValid), '0);
         next_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
